// File: rtl/noise_gate_pkg.sv
// Shared types for the noise gate: envelope state encoding and gain scaling.
package noise_gate_pkg;

    typedef enum logic [2:0] {CLOSED, ATTACK, OPEN, HOLD, RELEASE} state_t;

    localparam int GAIN_W = 9;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;

endpackage

// File: rtl/noise_gate_env.sv
// Envelope FSM, gain and hold counter. Attack/release ramps exist only with
// NOISE_GATE_RAMP_EN defined; otherwise the gate switches hard between 0 and unity.
module noise_gate_env
    import noise_gate_pkg::*;
#(
    parameter int WIDTH     = 31,
    parameter int HOLD_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 activate,
    input  logic                 sample_valid,
    input  logic [WIDTH-1:0]     mag,
    input  logic [WIDTH-1:0]     open_threshold,
    input  logic [WIDTH-1:0]     close_threshold,
    input  logic [HOLD_BITS-1:0] hold_samples,
    input  logic [7:0]           ramp_step,
    output logic [GAIN_W-1:0]    gain_now,
    output logic                 gate_open
);

    state_t               state, state_nxt;
    logic [GAIN_W-1:0]    gain, gain_nxt;
    logic [HOLD_BITS-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0]     close_eff;
    logic                 above_open;
    logic                 below_close;

    // Clamping close to open guarantees the hysteresis band never inverts.
    assign close_eff   = (close_threshold < open_threshold) ? close_threshold : open_threshold;
    assign above_open  = (mag >= open_threshold);
    assign below_close = (mag < close_eff);

`ifdef NOISE_GATE_RAMP_EN
    logic [GAIN_W-1:0] step, gain_up, gain_dn;
    logic [GAIN_W:0]   up_sum;

    assign step    = (ramp_step == 8'd0) ? 9'd1 : {1'b0, ramp_step};
    assign up_sum  = {1'b0, gain} + {1'b0, step};
    assign gain_up = (up_sum > {1'b0, GAIN_UNITY}) ? GAIN_UNITY : up_sum[GAIN_W-1:0];
    assign gain_dn = (gain > step) ? (gain - step) : '0;
`else
    logic unused_ramp;
    assign unused_ramp = ^ramp_step;
`endif

    always_comb begin
        state_nxt = state;
        gain_nxt  = gain;
        cnt_nxt   = cnt;
        case (state)
            CLOSED: begin
                gain_nxt = '0;
                if (above_open) begin
`ifdef NOISE_GATE_RAMP_EN
                    state_nxt = ATTACK;
                    gain_nxt  = gain_up;
`else
                    state_nxt = OPEN;
                    gain_nxt  = GAIN_UNITY;
`endif
                end
            end
`ifdef NOISE_GATE_RAMP_EN
            ATTACK: begin
                if (below_close) begin
                    state_nxt = RELEASE;
                    gain_nxt  = gain_dn;
                end else begin
                    gain_nxt = gain_up;
                    if (gain_up == GAIN_UNITY) state_nxt = OPEN;
                end
            end
            RELEASE: begin
                if (above_open) begin
                    state_nxt = ATTACK;
                    gain_nxt  = gain_up;
                end else begin
                    gain_nxt = gain_dn;
                    if (gain_dn == '0) state_nxt = CLOSED;
                end
            end
`endif
            OPEN: begin
                gain_nxt = GAIN_UNITY;
                if (below_close) begin
                    state_nxt = HOLD;
                    cnt_nxt   = hold_samples;
                end
            end
            HOLD: begin
                gain_nxt = GAIN_UNITY;
                if (above_open) begin
                    state_nxt = OPEN;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
`ifdef NOISE_GATE_RAMP_EN
                    state_nxt = RELEASE;
                    gain_nxt  = gain_dn;
`else
                    state_nxt = CLOSED;
                    gain_nxt  = '0;
`endif
                end
            end
            default: begin
                state_nxt = CLOSED;
                gain_nxt  = '0;
            end
        endcase
    end

    // Bypass parks the envelope at OPEN/unity so re-enabling causes no gain step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CLOSED;
            gain  <= '0;
            cnt   <= '0;
        end else if (!activate) begin
            state <= OPEN;
            gain  <= GAIN_UNITY;
        end else if (sample_valid) begin
            state <= state_nxt;
            gain  <= gain_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign gain_now  = gain_nxt;
    assign gate_open = (state != CLOSED);

endmodule

// File: rtl/noise_gate.sv
// Noise gate top: magnitude, gain multiply and output register around the envelope.
// Optional attack/release ramps are enabled by defining NOISE_GATE_RAMP_EN.
module noise_gate
    import noise_gate_pkg::*;
#(
    parameter int WIDTH     = 31,
    parameter int HOLD_BITS = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    activate,
    input  logic                    sample_valid,
    input  logic signed [WIDTH-1:0] cur_amplitude,
    input  logic [WIDTH-1:0]        open_threshold,
    input  logic [WIDTH-1:0]        close_threshold,
    input  logic [HOLD_BITS-1:0]    hold_samples,
    input  logic [7:0]              ramp_step,
    output logic signed [WIDTH-1:0] adj_cur_amplitude,
    output logic                    out_valid,
    output logic                    gate_open
);

    localparam int PW = WIDTH + GAIN_W + 1;

    function automatic logic [WIDTH-1:0] abs_sat(input logic signed [WIDTH-1:0] x);
        logic signed [WIDTH-1:0] most_neg;
        most_neg = {1'b1, {(WIDTH-1){1'b0}}};
        if (x == most_neg) return {1'b0, {(WIDTH-1){1'b1}}};
        if (x[WIDTH-1])    return $unsigned(-x);
        return $unsigned(x);
    endfunction

    logic [WIDTH-1:0]        mag;
    logic [GAIN_W-1:0]       gain_now;
    logic signed [PW-1:0]    prod;
    logic signed [WIDTH-1:0] gated;
    logic                    unused_bits;
    logic signed [WIDTH-1:0] adj_p1;
    logic                    vld_p1;

    assign mag = abs_sat(cur_amplitude);

    noise_gate_env #(
        .WIDTH     (WIDTH),
        .HOLD_BITS (HOLD_BITS)
    ) u_env (
        .clk             (clk),
        .reset           (reset),
        .activate        (activate),
        .sample_valid    (sample_valid),
        .mag             (mag),
        .open_threshold  (open_threshold),
        .close_threshold (close_threshold),
        .hold_samples    (hold_samples),
        .ramp_step       (ramp_step),
        .gain_now        (gain_now),
        .gate_open       (gate_open)
    );

    // Slicing bits [WIDTH+7:8] is the >>> 8 of the signed product, truncated.
    assign prod        = PW'(cur_amplitude) * PW'($signed({1'b0, gain_now}));
    assign gated       = prod[WIDTH+7:8];
    assign unused_bits = ^{prod[PW-1:WIDTH+8], prod[7:0]};

    // Stage p1: output register, updated only on strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adj_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= sample_valid;
            if (sample_valid) adj_p1 <= activate ? gated : cur_amplitude;
        end
    end

    assign adj_cur_amplitude = adj_p1;
    assign out_valid         = vld_p1;

endmodule

// File: tb/tb_noise_gate.sv
// Directed self-checking bench for noise_gate; expectations follow NOISE_GATE_RAMP_EN.
module tb_noise_gate;
    import noise_gate_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               activate;
    logic               sample_valid;
    logic signed [30:0] cur;
    logic [30:0]        open_threshold;
    logic [30:0]        close_threshold;
    logic [15:0]        hold_samples;
    logic [7:0]         ramp_step;
    logic signed [30:0] adj;
    logic               out_valid;
    logic               gate_open;

    int n_tests = 0;
    int n_fail  = 0;

    noise_gate dut (
        .clk               (clk),
        .reset             (reset),
        .activate          (activate),
        .sample_valid      (sample_valid),
        .cur_amplitude     (cur),
        .open_threshold    (open_threshold),
        .close_threshold   (close_threshold),
        .hold_samples      (hold_samples),
        .ramp_step         (ramp_step),
        .adj_cur_amplitude (adj),
        .out_valid         (out_valid),
        .gate_open         (gate_open)
    );

    always #5 clk = ~clk;

    // Drives one strobe just after an edge; returns 1 time unit after the capturing edge.
    task automatic send(input int v);
        sample_valid = 1'b1;
        cur          = 31'(v);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (adj !== 31'sd0 || out_valid !== 1'b0 || gate_open !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state adj=%0d valid=%b open=%b want 0/0/0", adj, out_valid, gate_open);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        send(100);
        n_tests++;
        if (adj !== 31'sd0 || out_valid !== 1'b1 || gate_open !== 1'b0) begin
            n_fail++;
            $display("FAIL first_sample adj=%0d valid=%b open=%b want 0/1/0", adj, out_valid, gate_open);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || adj !== 31'sd0) begin
            n_fail++;
            $display("FAIL valid_pulse valid=%b adj=%0d want 0/0", out_valid, adj);
        end
    endtask

`ifdef NOISE_GATE_RAMP_EN
    task automatic test_attack();
        int     ex[5] = '{500, 1000, 1500, 2000, 2000};
        state_t st[5] = '{ATTACK, ATTACK, ATTACK, OPEN, OPEN};
        for (int i = 0; i < 5; i++) begin
            send(2000);
            n_tests++;
            if (int'(adj) !== ex[i] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL attack[%0d] adj=%0d valid=%b want %0d/1", i, adj, out_valid, ex[i]);
            end
            n_tests++;
            if (dut.u_env.state !== st[i] || gate_open !== 1'b1) begin
                n_fail++;
                $display("FAIL attack_state[%0d] state=%0d open=%b want %0d/1", i, dut.u_env.state, gate_open, st[i]);
            end
        end
    endtask

    task automatic test_hold_release();
        int     vals[10] = '{100, 100, 100, 100, 100, -101, 1200, 300, 1200, 1200};
        int     ex[10]   = '{100, 100, 100, 100, 75, -51, 900, 150, 900, 1200};
        state_t st[10]   = '{HOLD, HOLD, HOLD, HOLD, RELEASE, RELEASE, ATTACK, RELEASE, ATTACK, OPEN};
        hold_samples = 16'd3;
        for (int i = 0; i < 10; i++) begin
            send(vals[i]);
            n_tests++;
            if (int'(adj) !== ex[i]) begin
                n_fail++;
                $display("FAIL hold_release[%0d] adj=%0d want %0d", i, adj, ex[i]);
            end
            n_tests++;
            if (dut.u_env.state !== st[i]) begin
                n_fail++;
                $display("FAIL hold_release_state[%0d] state=%0d want %0d", i, dut.u_env.state, st[i]);
            end
        end
    endtask

    localparam int NC = 7;
    int     close_vals[NC]  = '{100, 100, 100, 999, 1000, 1000, 1200};
    int     close_ramps[NC] = '{128, 128, 128, 128, 128, 0, 255};
    int     close_ex[NC]    = '{100, 50, 0, 0, 500, 503, 1200};
    state_t close_st[NC]    = '{HOLD, RELEASE, CLOSED, CLOSED, ATTACK, ATTACK, OPEN};
    localparam int     ASYNC_EX = 500;
    localparam state_t ASYNC_ST = ATTACK;
`else
    localparam int NC = 5;
    int     close_vals[NC]  = '{2000, 100, 100, 999, 1000};
    int     close_ramps[NC] = '{64, 64, 64, 64, 64};
    int     close_ex[NC]    = '{2000, 100, 0, 0, 1000};
    state_t close_st[NC]    = '{OPEN, HOLD, CLOSED, CLOSED, OPEN};
    localparam int     ASYNC_EX = 2000;
    localparam state_t ASYNC_ST = OPEN;
`endif

    task automatic test_close();
        hold_samples = 16'd0;
        for (int i = 0; i < NC; i++) begin
            ramp_step = 8'(close_ramps[i]);
            send(close_vals[i]);
            n_tests++;
            if (int'(adj) !== close_ex[i]) begin
                n_fail++;
                $display("FAIL close[%0d] adj=%0d want %0d", i, adj, close_ex[i]);
            end
            n_tests++;
            if (dut.u_env.state !== close_st[i] || gate_open !== (close_st[i] != CLOSED)) begin
                n_fail++;
                $display("FAIL close_state[%0d] state=%0d open=%b want %0d", i, dut.u_env.state, gate_open, close_st[i]);
            end
        end
        ramp_step = 8'd64;
    endtask

    task automatic test_hysteresis();
        close_threshold = 31'd5000;
        hold_samples    = 16'd0;
        send(1200);
        n_tests++;
        if (int'(adj) !== 1200 || dut.u_env.state !== OPEN) begin
            n_fail++;
            $display("FAIL hyst_stay adj=%0d state=%0d want 1200/OPEN", adj, dut.u_env.state);
        end
        send(800);
        n_tests++;
        if (int'(adj) !== 800 || dut.u_env.state !== HOLD) begin
            n_fail++;
            $display("FAIL hyst_close adj=%0d state=%0d want 800/HOLD", adj, dut.u_env.state);
        end
        close_threshold = 31'd500;
        hold_samples    = 16'd3;
    endtask

    task automatic test_bypass();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        activate = 1'b0;
        send(-(2 ** 30));
        n_tests++;
        if (int'(adj) !== -(2 ** 30) || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_neg adj=%0d valid=%b want %0d/1", adj, out_valid, -(2 ** 30));
        end
        send(7);
        n_tests++;
        if (int'(adj) !== 7 || gate_open !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_small adj=%0d open=%b want 7/1", adj, gate_open);
        end
        activate = 1'b1;
        send(600);
        n_tests++;
        if (int'(adj) !== 600 || dut.u_env.state !== OPEN) begin
            n_fail++;
            $display("FAIL bypass_rejoin adj=%0d state=%0d want 600/OPEN", adj, dut.u_env.state);
        end
        send(-(2 ** 30));
        n_tests++;
        if (int'(adj) !== -(2 ** 30) || dut.u_env.state !== OPEN) begin
            n_fail++;
            $display("FAIL most_neg_gated adj=%0d state=%0d want %0d/OPEN", adj, dut.u_env.state, -(2 ** 30));
        end
    endtask

    task automatic test_async_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        send(2000);
        n_tests++;
        if (int'(adj) !== ASYNC_EX || dut.u_env.state !== ASYNC_ST) begin
            n_fail++;
            $display("FAIL pre_reset adj=%0d state=%0d want %0d/%0d", adj, dut.u_env.state, ASYNC_EX, ASYNC_ST);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        n_tests++;
        if (adj !== 31'sd0 || out_valid !== 1'b0 || gate_open !== 1'b0 || dut.u_env.state !== CLOSED) begin
            n_fail++;
            $display("FAIL async_clear adj=%0d valid=%b open=%b state=%0d want 0/0/0/CLOSED",
                     adj, out_valid, gate_open, dut.u_env.state);
        end
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        send(2000);
        n_tests++;
        if (int'(adj) !== ASYNC_EX || dut.u_env.state !== ASYNC_ST) begin
            n_fail++;
            $display("FAIL post_reset adj=%0d state=%0d want %0d/%0d", adj, dut.u_env.state, ASYNC_EX, ASYNC_ST);
        end
    endtask

    initial begin
        reset           = 1'b0;
        activate        = 1'b1;
        sample_valid    = 1'b0;
        cur             = '0;
        open_threshold  = 31'd1000;
        close_threshold = 31'd500;
        hold_samples    = 16'd3;
        ramp_step       = 8'd64;
        test_reset();
`ifdef NOISE_GATE_RAMP_EN
        test_attack();
        test_hold_release();
`endif
        test_close();
        test_hysteresis();
        test_bypass();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/noise_gate.md
NOISE_GATE -- requirements
Module: noise_gate

Interface
REQ-001 SHALL have parameter WIDTH, default 31: sample width, signed two's complement.
REQ-002 SHALL have parameter HOLD_BITS, default 16: hold counter width.
REQ-003 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port activate, input, 1: 1 = gate the signal, 0 = bypass.
REQ-006 SHALL have port sample_valid, input, 1: one-cycle strobe marking a new cur_amplitude.
REQ-007 SHALL have port cur_amplitude, input, WIDTH: the incoming sample.
REQ-008 SHALL have port open_threshold, input, WIDTH: the magnitude at or above which the gate opens.
REQ-009 SHALL have port close_threshold, input, WIDTH: the magnitude below which the gate starts closing.
REQ-010 SHALL have port hold_samples, input, HOLD_BITS: the number of samples the gate stays open after the level drops.
REQ-011 SHALL have port ramp_step, input, 8: the gain change per sample during attack and release.
REQ-012 SHALL have port adj_cur_amplitude, output, WIDTH: the gated sample, registered.
REQ-013 SHALL have port out_valid, output, 1: strobe qualifying adj_cur_amplitude.
REQ-014 SHALL have port gate_open, output, 1: high when the state is not CLOSED.

Function
REQ-015 SHALL compute mag = |cur_amplitude|; -2^(WIDTH-1) saturates to 2^(WIDTH-1)-1.
REQ-016 SHALL use an effective close threshold of min(close_threshold, open_threshold), giving hysteresis.
REQ-017 SHALL use a 9-bit gain, range 0..256, with 256 = unity; a ramp_step of 0 SHALL be treated as 1.
REQ-018 SHALL advance the FSM and gain only on cycles where sample_valid=1 and activate=1.
REQ-019 CLOSED SHALL hold gain at 0 and go to ATTACK when mag >= open_threshold.
REQ-020 ATTACK SHALL set gain += step, saturating at 256; at 256 it SHALL go to OPEN; if mag < close it SHALL go to RELEASE, and the close test has priority.
REQ-021 OPEN SHALL hold gain at 256; when mag < close it SHALL go to HOLD and load the counter with hold_samples.
REQ-022 HOLD SHALL hold gain at 256 and go to OPEN when mag >= open_threshold; otherwise it SHALL decrement a nonzero counter, and a counter already at 0 SHALL go to RELEASE.
REQ-023 RELEASE SHALL set gain -= step, floored at 0; at 0 it SHALL go to CLOSED; when mag >= open_threshold it SHALL go to ATTACK, and that test has priority.
REQ-024 For each sample, SHALL use the gain after that sample's update for that sample.
REQ-025 SHALL compute adj_cur_amplitude = (cur_amplitude * gain) >>> 8, an arithmetic shift of the full WIDTH+9-bit product, truncated to WIDTH bits.
REQ-026 SHALL have a latency of exactly 1 cycle: out_valid is sample_valid delayed one cycle, and adj_cur_amplitude holds its value between strobes.
REQ-027 When activate=0, SHALL output adj_cur_amplitude = cur_amplitude with the same 1-cycle latency and force state OPEN with gain 256.
REQ-028 When activate rises, SHALL start gating from OPEN, so there is no step in gain.
REQ-029 SHALL ignore changes to threshold and ramp inputs between strobes; they are sampled only on valid cycles.

Reset
REQ-030 While reset=0, SHALL asynchronously clear adj_cur_amplitude, out_valid and the hold counter to 0, set state CLOSED and gain 0, and drive gate_open to 0.
REQ-031 SHALL abandon any attack, hold or release in progress on reset, with no residual state.

Configuration
REQ-032 With macro NOISE_GATE_RAMP_EN defined, SHALL use the ATTACK and RELEASE states as specified.
REQ-033 Without NOISE_GATE_RAMP_EN, SHALL omit ATTACK and RELEASE: CLOSED goes directly to OPEN with gain 256, HOLD expiry goes directly to CLOSED with gain 0, and ramp_step is unused.

Structure
REQ-034 SHALL take from package noise_gate_pkg the state enum (CLOSED, ATTACK, OPEN, HOLD, RELEASE), GAIN_UNITY=256 and GAIN_W=9.
REQ-035 SHALL place the FSM, gain and hold counter in sub-module noise_gate_env, with the magnitude, multiply and output registers in noise_gate.

Verification (for all scenarios unless stated: open=1000, close=500, ramp_step=64, activate=1, NOISE_GATE_RAMP_EN defined)
REQ-036 Reset release, sample 100 -> out 0, gate_open=0, out_valid exactly 1 cycle after sample_valid.
REQ-037 Five samples of 2000 from CLOSED -> outputs 500, 1000, 1500, 2000, 2000; OPEN reached on the 4th sample.
REQ-038 OPEN, hold_samples=3, then samples of 100 -> 100, 100, 100, 100, then 75 (RELEASE, gain 192).
REQ-039 RELEASE at gain 128, then sample 1200 -> ATTACK with gain 192 and out 900.
REQ-040 activate=0 with samples -2^30 and 7 -> outputs -2^30 and 7; after activate=1, sample 600 -> 600 (OPEN).
REQ-041 Reset asserted mid-ATTACK, between clock edges -> outputs 0 immediately; after release, the next sample 2000 -> 500.
REQ-042 Without the macro, sample 2000 -> 2000; then hold_samples=0 and samples of 100 -> 100, then 0 (CLOSED).
